filter_seq_ctrl: RTL and testbench
==================================

// Module: filter_seq_ctrl
// PURPOSE
//  Digital sequencer for one filter_p_m analog channel in the cochlea array.
//  Generates the cclk/div2 phase clocks and the lo mixer clock, and closes the
//  1-bit feedback loop: it samples high_buf on each phi1b_dig event and drives fb1.
//  Counts comparator highs per frame and hands each count to the readout via valid/ready.
// PARAMETERS
//  CDIV_W    8   width of cclk half-period divider config
//  LDIV_W    8   width of lo half-period divider config
//  CNT_W     12  width of frame length and frame count
//  WARM_EVT  2   events discarded after enable (loop settling)
// PORTS
//  wb_clk_i      in   1       system clock (only clock domain)
//  wb_rst_i      in   1       synchronous active-high reset
//  en            in   1       channel enable
//  cclk_half     in   CDIV_W  cclk half-period minus 1, in wb_clk_i cycles
//  lo_half       in   LDIV_W  lo half-period minus 1, in wb_clk_i cycles
//  frame_len     in   CNT_W   events per frame minus 1
//  high_buf      in   1       comparator output from macro (async)
//  phi1b_dig     in   1       event clock from macro (async)
//  cclk          out  1       to macro phase clkgen
//  div2          out  1       cclk/2, to macro phase clkgen
//  lo            out  1       to macro LO mux
//  fb1           out  1       feedback bit to macro
//  cnt_data      out  CNT_W   highs counted in last completed frame
//  cnt_valid     out  1       cnt_data valid
//  cnt_ready     in   1       consumer accepts cnt_data
//  overflow      out  1       sticky: a frame was dropped
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; all counters 0. Config is sampled live (no shadowing).
//  Sync: high_buf and phi1b_dig each pass through 2 flops; event = falling edge of
//   synced phi1b_dig (registered edge detect). Event pulse is 1 cycle, 3 cycles after input edge.
//  FSM IDLE -> WARM on en=1; WARM -> RUN after WARM_EVT events; any state -> IDLE when en=0.
//  IDLE: cclk, div2, lo, fb1 held 0; dividers, event and high counters cleared.
//   A pending cnt_valid is held until accepted; overflow cleared on IDLE entry.
//  WARM/RUN clocks: cclk divider counts 0..cclk_half, toggles cclk at terminal, then reloads 0.
//   div2 toggles on each cclk 0->1 transition (same cycle cclk rises).
//   lo divider is independent: toggles lo every lo_half+1 cycles. First toggles occur
//   cclk_half+1 / lo_half+1 cycles after leaving IDLE.
//  Event (WARM or RUN): fb1 <= synced high_buf, the cycle after the event pulse.
//  WARM: events only counted toward WARM_EVT; no highs accumulated.
//  RUN: each event increments evt_cnt; if synced high=1, hi_cnt increments (saturating at max).
//   When an event arrives with evt_cnt==frame_len: frame ends; the final sample is included
//   in the frame total; evt_cnt and hi_cnt reset to 0 for the next frame.
//   If cnt_valid=0, or cnt_valid&cnt_ready in that same cycle: cnt_data <= total,
//   cnt_valid <= 1 the next cycle. Otherwise the new total is dropped, old data kept, overflow <= 1.
//  Handshake: transfer when cnt_valid&cnt_ready; cnt_valid drops the next cycle unless a new
//   frame loads simultaneously (then stays 1 with new data). cnt_data stable while valid&!ready.
//  frame_len=0: every event is a frame (count 0 or 1).
//  en low mid-frame: partial frame discarded, no cnt_valid issued.
//  wb_rst_i mid-operation: immediate return to reset values next edge, including pending data.
// TESTING
//  T1 reset: assert wb_rst_i 2 cycles while en=1 -> all outputs 0, FSM IDLE.
//  T2 clocks: cclk_half=3, lo_half=1, en=1 -> cclk period 8 cyc, div2 16 cyc, lo 4 cyc.
//  T3 warm+fb: WARM_EVT=2, high_buf=1, 3 phi1b falls -> fb1=1 3+1 cyc after 1st; hi_cnt counts only 3rd.
//  T4 frame: frame_len=3, highs pattern 1,0,1,1 in RUN, ready=1 -> cnt_data=3, cnt_valid 1-cycle pulse.
//  T5 backpressure: ready=0 across 2 frame ends -> 1st count held, overflow=1; ready=1 clears valid.
//  T6 en drop: en=0 after 2 of 4 events -> clocks/fb1 0 next cycle, no cnt_valid, overflow cleared.

Source files
------------

// File: rtl/filter_seq_ctrl.sv
// Sequencer for one filter channel: phase/LO clock dividers, 1-bit feedback loop, per-frame high counter.
// Latency: event pulse 3 cycles after a phi1b_dig fall; fb1 and frame count registered one cycle after the event.
// Backpressure: cnt_valid/cnt_ready; a frame ending while the previous count is unaccepted is dropped and flags overflow.
module filter_seq_ctrl #(
    parameter int CDIV_W   = 8,
    parameter int LDIV_W   = 8,
    parameter int CNT_W    = 12,
    parameter int WARM_EVT = 2
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              en,
    input  logic [CDIV_W-1:0] cclk_half,
    input  logic [LDIV_W-1:0] lo_half,
    input  logic [CNT_W-1:0]  frame_len,
    input  logic              high_buf,
    input  logic              phi1b_dig,
    output logic              cclk,
    output logic              div2,
    output logic              lo,
    output logic              fb1,
    output logic [CNT_W-1:0]  cnt_data,
    output logic              cnt_valid,
    input  logic              cnt_ready,
    output logic              overflow
);

    typedef enum logic [1:0] {S_IDLE, S_WARM, S_RUN} state_t;

    localparam int WW = (WARM_EVT > 1) ? $clog2(WARM_EVT) : 1;
    localparam logic [WW-1:0] WARM_LAST = WW'(WARM_EVT - 1);

    state_t            state_q, state_d;
    logic              hb_s1_q, hb_s2_q;
    logic              ph_s1_q, ph_s2_q, ph_dly_q;
    logic              evt_q, evt_d;
    logic [CDIV_W-1:0] cdiv_q, cdiv_d;
    logic [LDIV_W-1:0] ldiv_q, ldiv_d;
    logic              cclk_q, cclk_d, div2_q, div2_d, lo_q, lo_d, fb1_q, fb1_d;
    logic [WW-1:0]     warm_q, warm_d;
    logic [CNT_W-1:0]  evt_cnt_q, evt_cnt_d, hi_cnt_q, hi_cnt_d, hi_inc;
    logic [CNT_W-1:0]  data_q, data_d;
    logic              valid_q, valid_d, ovf_q, ovf_d;
    logic              run_ok, frame_end, xfer;

    // Falling edge of the synchronised event clock, registered into a one-cycle pulse.
    assign evt_d  = ph_dly_q & ~ph_s2_q;
    assign run_ok = en && (state_q != S_IDLE);
    assign xfer   = valid_q & cnt_ready;
    // Saturating high count including the current synced sample.
    assign hi_inc = (&hi_cnt_q) ? hi_cnt_q : hi_cnt_q + {{(CNT_W-1){1'b0}}, hb_s2_q};

    // State and datapath registers with synchronous reset.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q   <= S_IDLE;
            hb_s1_q   <= 1'b0;
            hb_s2_q   <= 1'b0;
            ph_s1_q   <= 1'b0;
            ph_s2_q   <= 1'b0;
            ph_dly_q  <= 1'b0;
            evt_q     <= 1'b0;
            cdiv_q    <= '0;
            ldiv_q    <= '0;
            cclk_q    <= 1'b0;
            div2_q    <= 1'b0;
            lo_q      <= 1'b0;
            fb1_q     <= 1'b0;
            warm_q    <= '0;
            evt_cnt_q <= '0;
            hi_cnt_q  <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            hb_s1_q   <= high_buf;
            hb_s2_q   <= hb_s1_q;
            ph_s1_q   <= phi1b_dig;
            ph_s2_q   <= ph_s1_q;
            ph_dly_q  <= ph_s2_q;
            evt_q     <= evt_d;
            cdiv_q    <= cdiv_d;
            ldiv_q    <= ldiv_d;
            cclk_q    <= cclk_d;
            div2_q    <= div2_d;
            lo_q      <= lo_d;
            fb1_q     <= fb1_d;
            warm_q    <= warm_d;
            evt_cnt_q <= evt_cnt_d;
            hi_cnt_q  <= hi_cnt_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ovf_q     <= ovf_d;
        end
    end

    // Channel FSM: enable starts warm-up, WARM_EVT events settle the loop, enable low aborts.
    always_comb begin
        state_d = state_q;
        if (!en) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  state_d = (WARM_EVT == 0) ? S_RUN : S_WARM;
                S_WARM:  if (evt_q && warm_q == WARM_LAST) state_d = S_RUN;
                S_RUN:   state_d = S_RUN;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Dividers, feedback bit, frame counting and the count handshake.
    always_comb begin
        cdiv_d    = cdiv_q;
        ldiv_d    = ldiv_q;
        cclk_d    = cclk_q;
        div2_d    = div2_q;
        lo_d      = lo_q;
        fb1_d     = fb1_q;
        warm_d    = warm_q;
        evt_cnt_d = evt_cnt_q;
        hi_cnt_d  = hi_cnt_q;
        data_d    = data_q;
        valid_d   = valid_q;
        ovf_d     = ovf_q;
        frame_end = 1'b0;

        if (!run_ok) begin
            cdiv_d    = '0;
            ldiv_d    = '0;
            cclk_d    = 1'b0;
            div2_d    = 1'b0;
            lo_d      = 1'b0;
            fb1_d     = 1'b0;
            warm_d    = '0;
            evt_cnt_d = '0;
            hi_cnt_d  = '0;
        end else begin
            if (cdiv_q == cclk_half) begin
                cdiv_d = '0;
                cclk_d = ~cclk_q;
                if (!cclk_q) div2_d = ~div2_q;
            end else begin
                cdiv_d = cdiv_q + CDIV_W'(1);
            end
            if (ldiv_q == lo_half) begin
                ldiv_d = '0;
                lo_d   = ~lo_q;
            end else begin
                ldiv_d = ldiv_q + LDIV_W'(1);
            end
            if (evt_q) begin
                fb1_d = hb_s2_q;
                if (state_q == S_WARM) begin
                    warm_d = warm_q + WW'(1);
                end else if (state_q == S_RUN) begin
                    if (evt_cnt_q == frame_len) begin
                        frame_end = 1'b1;
                        evt_cnt_d = '0;
                        hi_cnt_d  = '0;
                    end else begin
                        evt_cnt_d = evt_cnt_q + CNT_W'(1);
                        hi_cnt_d  = hi_inc;
                    end
                end
            end
        end

        if (xfer) valid_d = 1'b0;
        if (frame_end) begin
            if (!valid_q || xfer) begin
                data_d  = hi_inc;
                valid_d = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end
        if (state_q != S_IDLE && state_d == S_IDLE) ovf_d = 1'b0;
    end

    assign cclk      = cclk_q;
    assign div2      = div2_q;
    assign lo        = lo_q;
    assign fb1       = fb1_q;
    assign cnt_data  = data_q;
    assign cnt_valid = valid_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_filter_seq_ctrl.sv
// Directed bench for filter_seq_ctrl: reset, divider timing, warm-up/feedback, frames, backpressure, enable drop.
// Outputs sampled on the falling clock edge; inputs driven on the falling edge after sampling.
// Fixed-length stimulus only, so the run always reaches its summary line.
module tb_filter_seq_ctrl;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i = 1'b1;
    logic        en = 1'b1;
    logic [7:0]  cclk_half = 8'd3;
    logic [7:0]  lo_half = 8'd1;
    logic [11:0] frame_len = 12'd0;
    logic        high_buf = 1'b1;
    logic        phi1b_dig = 1'b0;
    logic        cclk, div2, lo, fb1, cnt_valid, overflow;
    logic [11:0] cnt_data;
    logic        cnt_ready = 1'b1;

    int n_checks = 0;
    int n_fail = 0;

    filter_seq_ctrl dut (
        .wb_clk_i  (wb_clk_i),
        .wb_rst_i  (wb_rst_i),
        .en        (en),
        .cclk_half (cclk_half),
        .lo_half   (lo_half),
        .frame_len (frame_len),
        .high_buf  (high_buf),
        .phi1b_dig (phi1b_dig),
        .cclk      (cclk),
        .div2      (div2),
        .lo        (lo),
        .fb1       (fb1),
        .cnt_data  (cnt_data),
        .cnt_valid (cnt_valid),
        .cnt_ready (cnt_ready),
        .overflow  (overflow)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One phi1b_dig pulse with the given comparator level; returns at the
    // falling edge after the cycle in which the event is processed.
    task automatic do_evt(input logic hb);
        high_buf  = hb;
        phi1b_dig = 1'b1;
        repeat (3) @(negedge wb_clk_i);
        phi1b_dig = 1'b0;
        repeat (4) @(negedge wb_clk_i);
    endtask

    logic cc_s[0:40];
    logic d2_s[0:40];
    logic lo_s[0:40];

    initial begin
        int c1, c2, cf, d1, d2, l1, l2;

        // T1: reset held two cycles with enable high
        repeat (2) @(negedge wb_clk_i);
        chk("rst_cclk", cclk, 0);
        chk("rst_div2", div2, 0);
        chk("rst_lo", lo, 0);
        chk("rst_fb1", fb1, 0);
        chk("rst_valid", cnt_valid, 0);
        chk("rst_data", cnt_data, 0);
        chk("rst_ovf", overflow, 0);

        // T2: divider timing from the cycle reset is released
        cc_s[0] = cclk; d2_s[0] = div2; lo_s[0] = lo;
        wb_rst_i = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge wb_clk_i);
            cc_s[k] = cclk; d2_s[k] = div2; lo_s[k] = lo;
        end
        c1 = -1; c2 = -1; cf = -1; d1 = -1; d2 = -1; l1 = -1; l2 = -1;
        for (int k = 1; k <= 40; k++) begin
            if (cc_s[k] && !cc_s[k-1]) begin
                if (c1 < 0) c1 = k; else if (c2 < 0) c2 = k;
            end
            if (!cc_s[k] && cc_s[k-1] && cf < 0) cf = k;
            if (d2_s[k] && !d2_s[k-1]) begin
                if (d1 < 0) d1 = k; else if (d2 < 0) d2 = k;
            end
            if (lo_s[k] && !lo_s[k-1]) begin
                if (l1 < 0) l1 = k; else if (l2 < 0) l2 = k;
            end
        end
        chk("cclk_rise1", c1, 5);
        chk("cclk_fall1", cf, 9);
        chk("cclk_rise2", c2, 13);
        chk("div2_rise1", d1, 5);
        chk("div2_rise2", d2, 21);
        chk("lo_rise1", l1, 3);
        chk("lo_rise2", l2, 7);

        // T3: warm-up events, feedback timing, only the third event counted
        frame_len = 12'd0;
        high_buf  = 1'b1;
        phi1b_dig = 1'b1;
        repeat (3) @(negedge wb_clk_i);
        phi1b_dig = 1'b0;
        repeat (3) @(negedge wb_clk_i);
        chk("fb1_before", fb1, 0);
        @(negedge wb_clk_i);
        chk("fb1_after", fb1, 1);
        chk("warm1_valid", cnt_valid, 0);
        do_evt(1'b1);
        chk("warm2_valid", cnt_valid, 0);
        do_evt(1'b1);
        chk("run1_valid", cnt_valid, 1);
        chk("run1_data", cnt_data, 1);
        @(negedge wb_clk_i);
        chk("run1_drop", cnt_valid, 0);

        // T4: four-event frame with highs 1,0,1,1
        frame_len = 12'd3;
        do_evt(1'b1);
        chk("f4_e1_valid", cnt_valid, 0);
        do_evt(1'b0);
        chk("f4_e2_fb1", fb1, 0);
        do_evt(1'b1);
        chk("f4_e3_valid", cnt_valid, 0);
        do_evt(1'b1);
        chk("f4_valid", cnt_valid, 1);
        chk("f4_data", cnt_data, 3);
        @(negedge wb_clk_i);
        chk("f4_pulse", cnt_valid, 0);

        // T5: two frame ends with the consumer stalled
        frame_len = 12'd1;
        cnt_ready = 1'b0;
        do_evt(1'b1);
        do_evt(1'b1);
        chk("bp_a_valid", cnt_valid, 1);
        chk("bp_a_data", cnt_data, 2);
        chk("bp_a_ovf", overflow, 0);
        do_evt(1'b1);
        do_evt(1'b0);
        chk("bp_b_valid", cnt_valid, 1);
        chk("bp_b_data", cnt_data, 2);
        chk("bp_b_ovf", overflow, 1);
        cnt_ready = 1'b1;
        @(negedge wb_clk_i);
        chk("bp_acc_valid", cnt_valid, 0);
        chk("bp_acc_ovf", overflow, 1);

        // T6: enable dropped after two of four events
        frame_len = 12'd3;
        do_evt(1'b1);
        do_evt(1'b1);
        chk("en_pre_fb1", fb1, 1);
        en = 1'b0;
        @(negedge wb_clk_i);
        chk("en_cclk", cclk, 0);
        chk("en_div2", div2, 0);
        chk("en_lo", lo, 0);
        chk("en_fb1", fb1, 0);
        chk("en_ovf", overflow, 0);
        repeat (10) @(negedge wb_clk_i);
        chk("en_valid", cnt_valid, 0);
        chk("en_lo_held", lo, 0);

        // Re-enable: warm-up again, then a fresh frame with highs 0,0,0,1
        en = 1'b1;
        do_evt(1'b0);
        do_evt(1'b0);
        do_evt(1'b0);
        do_evt(1'b0);
        do_evt(1'b0);
        chk("re_mid_valid", cnt_valid, 0);
        do_evt(1'b1);
        chk("re_valid", cnt_valid, 1);
        chk("re_data", cnt_data, 1);

        // Reset mid-operation clears a pending count
        cnt_ready = 1'b0;
        @(negedge wb_clk_i);
        wb_rst_i = 1'b1;
        @(negedge wb_clk_i);
        chk("rst2_valid", cnt_valid, 0);
        chk("rst2_data", cnt_data, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
